// File: rtl/cpu_trace_pkg.sv
// Shared types and helpers for the CPU trace capture unit: capture state
// encoding and the routine that packs a timestamp and channel sample into
// one FIFO entry.
package cpu_trace_pkg;

  // State encodings, visible on the state output
  localparam logic [1:0] ST_ENC_IDLE    = 2'd0;
  localparam logic [1:0] ST_ENC_ARMED   = 2'd1;
  localparam logic [1:0] ST_ENC_CAPTURE = 2'd2;
  localparam logic [1:0] ST_ENC_DONE    = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = ST_ENC_IDLE,
    ST_ARMED   = ST_ENC_ARMED,
    ST_CAPTURE = ST_ENC_CAPTURE,
    ST_DONE    = ST_ENC_DONE
  } trace_state_t;

  // Widest entry the packing helper can build; callers truncate to their
  // own entry width, so TS_W + NCH*DATA_W must not exceed this.
  localparam int PACK_W = 256;

  // Place the timestamp directly above the data_bits-wide channel sample.
  function automatic logic [PACK_W-1:0] pack_entry(
    input logic [PACK_W-1:0] ts,
    input logic [PACK_W-1:0] data,
    input int                data_bits
  );
    pack_entry = (ts << data_bits) | data;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous first-word-fall-through FIFO for trace entries. The head entry
// is read combinationally from storage. flush empties it and wins over any
// same-cycle push or pop. With overwrite set, a push into a full FIFO
// discards the oldest entry instead of being dropped.
module trace_fifo
  import cpu_trace_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic                   overwrite,
  input  logic [WIDTH-1:0]       data_in,
  output logic [WIDTH-1:0]       data_out,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             do_pop;
  logic             do_push;
  logic             drop_old;

  assign full     = (count_reg == FULL_CNT);
  assign empty    = (count_reg == '0);
  assign count    = count_reg;
  assign data_out = mem[rd_ptr_reg];

  // Decide which of push/pop actually take effect this cycle
  always_comb begin
    do_pop   = pop && !empty && !flush;
    do_push  = push && !flush && (!full || do_pop || overwrite);
    // Full, pushing and nothing leaving: the oldest entry makes room
    drop_old = do_push && full && !do_pop;
  end

  // Storage write port; a full-FIFO write lands on the slot being vacated
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= data_in;
    end
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (do_pop || drop_old) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      if (do_push && !do_pop && !full) begin
        count_reg <= count_reg + 1'b1;
      end else if (do_pop && !do_push) begin
        count_reg <= count_reg - 1'b1;
      end
    end
  end

endmodule

// File: rtl/cpu_trace_capture.sv
// Trace capture unit: samples NCH CPU channels, stamps each sample with a
// free-running cycle counter and buffers it in a FIFO under arm/trig/stop
// control. Supports change-only sampling and ring-buffer (wrap) mode; the
// buffer drains through a valid/ready port in any state.
module cpu_trace_capture
  import cpu_trace_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NCH    = 2,
  parameter int DEPTH  = 16,
  parameter int TS_W   = 16
) (
  input  logic                          CLK,
  input  logic                          reset,
  input  logic [NCH*DATA_W-1:0]         ch_data,
  input  logic                          arm,
  input  logic                          trig,
  input  logic                          stop,
  input  logic                          change_only,
  input  logic                          wrap_mode,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [TS_W+NCH*DATA_W-1:0]    out_data,
  output logic [$clog2(DEPTH):0]        count,
  output logic                          overflow,
  output logic [1:0]                    state
);

  localparam int CH_W    = NCH * DATA_W;
  localparam int ENTRY_W = TS_W + CH_W;
  localparam int CNT_W   = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEPTH - 1);

  trace_state_t      state_reg;
  logic [TS_W-1:0]   ts_reg;
  logic [CH_W-1:0]   prev_reg;
  logic              overflow_reg;

  logic              write_req;
  logic              pop;
  logic              flush;
  logic              auto_full;
  logic              fifo_full;
  logic              fifo_empty;
  logic [ENTRY_W-1:0] entry;

  // Sample now if capturing and either every cycle or the channels moved
  assign write_req = (state_reg == ST_CAPTURE) && (!change_only || (ch_data != prev_reg));
  assign pop       = out_valid && out_ready;
  // arm only acts (and only flushes) from IDLE or DONE
  assign flush     = arm && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));
  // Without wrap, the write that fills the buffer ends the capture
  assign auto_full = write_req && !wrap_mode && (fifo_full || ((count == LAST_CNT) && !pop));
  assign entry     = ENTRY_W'(pack_entry(PACK_W'(ts_reg), PACK_W'(ch_data), CH_W));

  assign out_valid = !fifo_empty;
  assign overflow  = overflow_reg;
  assign state     = state_reg;

  trace_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (CLK),
    .rst_n     (reset),
    .push      (write_req),
    .pop       (pop),
    .flush     (flush),
    .overwrite (wrap_mode),
    .data_in   (entry),
    .data_out  (out_data),
    .count     (count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Capture control FSM; stop outranks the full-buffer exit, trig outranks stop in ARMED
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE:    if (arm) state_reg <= ST_ARMED;
        ST_ARMED:   if (trig) state_reg <= ST_CAPTURE;
        ST_CAPTURE: if (stop || auto_full) state_reg <= ST_DONE;
        ST_DONE:    if (arm) state_reg <= ST_ARMED;
        default:    state_reg <= ST_IDLE;
      endcase
    end
  end

  // Free-running timestamp, wraps naturally at 2^TS_W
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      ts_reg <= '0;
    end else begin
      ts_reg <= ts_reg + 1'b1;
    end
  end

  // Previous-cycle channel value for change detection
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      prev_reg <= '0;
    end else begin
      prev_reg <= ch_data;
    end
  end

  // Sticky overflow: set when wrap mode pushes out an unread entry, cleared by arm
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      overflow_reg <= 1'b0;
    end else if (flush) begin
      overflow_reg <= 1'b0;
    end else if (write_req && fifo_full && wrap_mode && !pop) begin
      overflow_reg <= 1'b1;
    end
  end

endmodule

// File: doc/cpu_trace_capture.md
# cpu_trace_capture

Parametrised, synthesizable trace capture unit for the single-cycle CPU. It samples NCH monitored CPU channels (ALUResult, cpu_out, …) of DATA_W bits each, stamps them with a free-running cycle counter, and buffers them in a DEPTH-entry FIFO with arm/trigger/stop control. A valid/ready drain port lets a bench or a debug UART read the buffer. It replaces free-running $monitor printing with on-chip capture that supports change-only sampling and ring-buffer mode.

## Interface
- DATA_W, 8, width of one monitored channel
- NCH, 2, number of channels; ch_data packs channel 0 in the LSBs
- DEPTH, 16, FIFO entries; must be a power of two, at least 2
- TS_W, 16, timestamp width
- ENTRY_W, derived as TS_W+NCH*DATA_W; not overridable

- CLK  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset)
- ch_data  in  NCH*DATA_W  monitored channels
- arm  in  1  pulse; IDLE/DONE -> ARMED, flushes FIFO, clears overflow
- trig  in  1  ARMED -> CAPTURE
- stop  in  1  CAPTURE -> DONE
- change_only  in  1  0 = sample every CAPTURE cycle; 1 = sample only when ch_data differs from the previous cycle's value
- wrap_mode  in  1  0 = stop when full; 1 = overwrite oldest entry
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  consumer accepts head entry
- out_data  out  ENTRY_W  head entry {timestamp, ch_data}, timestamp in MSBs
- count  out  $clog2(DEPTH)+1  entries held
- overflow  out  1  sticky; an entry was overwritten or dropped
- state  out  2  IDLE=0, ARMED=1, CAPTURE=2, DONE=3

## Operation
- Reset values: state IDLE, count 0, out_valid 0, overflow 0, timestamp 0, prev-sample register 0. out_data is don't-care while out_valid is 0.
- Timestamp increments every cycle after reset release, whatever the state, and wraps from 2^TS_W-1 to 0.
- The prev register loads ch_data every cycle.
- A write request occurs in CAPTURE when change_only=0, or when change_only=1 and ch_data != prev.
- The written entry is {timestamp of that cycle, ch_data of that cycle}.
- FSM transitions:
  - IDLE -arm-> ARMED
  - ARMED -trig-> CAPTURE; the trig cycle itself is not sampled
  - CAPTURE -stop-> DONE; the stop cycle is still sampled
  - CAPTURE -> DONE automatically when wrap_mode=0 and a write makes count reach DEPTH
  - DONE -arm-> ARMED
  - arm is ignored in ARMED and CAPTURE.
- Priority: stop over the automatic-full transition. If trig and stop arrive together in ARMED, only trig acts.
- Pop happens on out_valid && out_ready, and is allowed in every state. A flush by arm discards any pop in the same cycle.
- Full with a write request:
  - wrap_mode=1, no pop: oldest entry is discarded, the new one written, count stays DEPTH, overflow set.
  - wrap_mode=0: cannot occur in CAPTURE because of the automatic DONE transition. overflow is not set.
  - Any mode, with a same-cycle pop: push and pop both proceed, count unchanged.
- Empty with a pop: not possible, because out_valid is 0.
- wrap_mode and change_only are sampled every cycle. Changing them mid-capture takes effect immediately.

## Timing
- Write at edge N: out_valid, count and out_data reflect it after edge N. out_data is first-word-fall-through, driven combinationally from storage.
- Pop at edge N: the next entry is presented after edge N.
- State output changes on the edge at which the triggering input is sampled high.
- Asserting reset mid-capture clears everything immediately, without waiting for CLK. On release, the first count-up edge gives timestamp 1.

## Structure
- Shared package cpu_trace_pkg holds:
  - the state enum typedef (trace_state_t)
  - state encoding constants
  - an entry-packing function
- Sub-module trace_fifo is a synchronous FIFO with parameters WIDTH and DEPTH.
  - Ports: push, pop, flush, overwrite, data_in, data_out, count, full, empty.
  - The top level contains the FSM, timestamp counter, change detector and overflow flag.

## Test plan
- Every-cycle capture (default parameters):
  - Stimulus: arm, trig at timestamp 10, stop at timestamp 14, out_ready=0.
  - Required: state=DONE; count=4; entries carry timestamps 11..14 in order with matching ch_data; overflow=0.
- Change-only capture:
  - Stimulus: change_only=1; ch_data 0x0505 held for 5 CAPTURE cycles, then 0x0506, then held.
  - Required: exactly one entry, 0x0506, with the timestamp of its change cycle (plus one entry at capture start if it differs from prev).
- Stop-on-full:
  - Stimulus: wrap_mode=0, DEPTH=16, no drain.
  - Required: after the 16th write, state=DONE, count=16, overflow=0; further ch_data changes are ignored.
- Wrap mode:
  - Stimulus: wrap_mode=1, 20 writes, then stop.
  - Required: count=16, overflow=1, head timestamp equals that of the 5th write.
- Drain handshake:
  - Stimulus: toggle out_ready 1/0 while capturing every cycle at full occupancy.
  - Required: simultaneous push/pop keeps count constant; no entry is lost or duplicated; a scoreboard matches the sequence.
- Reset and re-arm:
  - Stimulus: assert reset (0) mid-CAPTURE between clock edges.
  - Required: immediate IDLE, count=0, out_valid=0, overflow=0.
  - Stimulus: arm from DONE with 3 entries buffered.
  - Required: count=0, overflow=0 on the next edge.
